div_controller: RTL and testbench
=================================

Name: div_controller

Overview:
- FSM that sequences the repeated-subtraction divider datapath (div_datapath) through clear, dividend load, divisor load, subtract loop and result capture.
- Sits between a host (start/done handshake, drives Data_in) and the datapath. Consumes PgtN; drives every datapath control strobe.
- Bounds the subtract loop with an iteration counter, so a zero divisor cannot hang the block.

Parameters:
- CNT_W, 8, width of the iteration counter; matches the datapath width.
- MAX_ITER, 255, maximum incQ pulses per division before an overflow error is raised.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  host request; sampled only in IDLE
- data_zero  in  1  high when Data_in == 0; used only with DIV_ZERO_CHECK_EN
- PgtN  in  1  datapath compare flag, dividend >= divisor
- clear  out  1  datapath clear strobe
- loadN  out  1  load dividend from Data_in; the host must present the dividend this cycle
- loadP  out  1  load divisor from Data_in; the host must present the divisor this cycle
- loadS  out  1  tied 0; all subtraction is issued on incQ
- incQ  out  1  subtract divisor and increment quotient
- stop  out  1  capture Res/Rem in the datapath
- busy  out  1  high from CLR through DONE
- done  out  1  one-cycle completion pulse
- err  out  1  error flag; valid with done and held until the next start

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, iter_cnt=0. clear, loadN, loadP, loadS, incQ, stop, busy, done and err all 0. rst dominates in every state, including mid-division; no stop is issued on reset.
- States: IDLE, CLR, LDN, LDP, ITER, DONE. Encoding is implementer's choice; no illegal state may lock up (default -> IDLE).
- IDLE: all strobes 0. start=1 -> CLR and err<=0.
- CLR: clear=1, iter_cnt<=0 -> LDN.
- LDN: loadN=1 -> LDP.
- LDP: loadP=1 -> ITER.
- ITER (Mealy outputs from PgtN):
  - PgtN=1 and iter_cnt<MAX_ITER: incQ=1, iter_cnt+=1, stay in ITER.
  - PgtN=0: stop=1 -> DONE.
  - PgtN=1 and iter_cnt==MAX_ITER: stop=1, err<=1 -> DONE.
- DONE: done=1 -> IDLE. busy is 0 from IDLE onward.
- Only one incQ is issued per cycle. PgtN is re-evaluated each ITER cycle against the updated datapath registers.
- Latency, with start sampled at edge 0 and Q = quotient:
  - clear at cycle 1, loadN at 2, loadP at 3.
  - incQ at cycles 4..3+Q; stop at cycle 4+Q; done at cycle 5+Q.
- start is ignored while busy; there is no queuing. start held high in DONE does not retrigger until the state has returned to IDLE; a retrigger is taken on the next cycle.
- iter_cnt saturates at MAX_ITER and never wraps.
- A dividend smaller than the divisor gives zero incQ pulses: stop at cycle 4, done at cycle 5.

Optional Feature:
- Macro DIV_ZERO_CHECK_EN.
- Defined: data_zero is sampled in LDP. If 1, the next state is DONE via a single stop cycle (state STOPZ), err<=1, and no incQ is issued. done therefore comes at cycle 5.
- Undefined: data_zero is ignored. A zero divisor yields MAX_ITER incQ pulses, then the overflow path sets err=1.

Decomposition:
- Shared package div_pkg holds:
  - state enum div_state_t (IDLE, CLR, LDN, LDP, ITER, STOPZ, DONE)
  - DIV_W=8
  - DEFAULT_MAX_ITER=255
- Optional sub-module div_iter_counter: saturating counter with clr, inc and at_max outputs. Everything else stays in one module.

Test Plan:
- Dividend 20, divisor 6 -> 3 incQ pulses (cycles 4-6), stop at 7, done at 8, err=0. With the datapath attached: Res=3, Rem=2.
- Dividend 5, divisor 7 -> no incQ, stop at cycle 4, done at 5. Res=0, Rem=5.
- Dividend 255, divisor 1 -> exactly 255 incQ pulses, err=0, done at cycle 260, Res=255, Rem=0.
- Divisor 0, dividend 9:
  - macro off: 255 incQ pulses, then err=1 with done.
  - macro on: zero incQ pulses, err=1, done at cycle 5.
- rst asserted during ITER after 2 incQ pulses -> next cycle all outputs 0, state IDLE. A new start runs a full clean sequence beginning with clear.
- start pulsed at cycles 2 and 6 of an active division -> ignored; exactly one done is produced per accepted start.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and defaults for the repeated-subtraction divider
package div_pkg;

  localparam int DIV_W            = 8;
  localparam int DEFAULT_MAX_ITER = 255;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LDN,
    LDP,
    ITER,
    STOPZ,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_iter_counter.sv
// rtl/div_iter_counter.sv - saturating iteration counter bounding the subtract loop
module div_iter_counter
  import div_pkg::*;
#(
  parameter int W   = DIV_W,
  parameter int MAX = DEFAULT_MAX_ITER
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] count;

  // Holds at MAX_V so a stuck compare flag can never wrap the count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + W'(1);
    end
  end

  assign at_max = (count == MAX_V);

endmodule

// File: rtl/div_controller.sv
// rtl/div_controller.sv - divider sequencing FSM; DIV_ZERO_CHECK_EN adds early zero-divisor stop
module div_controller
  import div_pkg::*;
#(
  parameter int CNT_W    = DIV_W,
  parameter int MAX_ITER = DEFAULT_MAX_ITER
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic data_zero,
  input  logic PgtN,
  output logic clear,
  output logic loadN,
  output logic loadP,
  output logic loadS,
  output logic incQ,
  output logic stop,
  output logic busy,
  output logic done,
  output logic err
);

  div_state_t state;
  div_state_t state_next;
  logic       at_max;
  logic       err_set;
  logic       err_clr;

  div_iter_counter #(
    .W   (CNT_W),
    .MAX (MAX_ITER)
  ) u_iter_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (clear),
    .inc    (incQ),
    .at_max (at_max)
  );

`ifndef DIV_ZERO_CHECK_EN
  logic unused_data_zero;
  assign unused_data_zero = data_zero;
`endif

  assign loadS = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      if (err_clr) begin
        err <= 1'b0;
      end else if (err_set) begin
        err <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    clear      = 1'b0;
    loadN      = 1'b0;
    loadP      = 1'b0;
    incQ       = 1'b0;
    stop       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CLR;
          err_clr    = 1'b1;
        end
      end
      CLR: begin
        busy       = 1'b1;
        clear      = 1'b1;
        state_next = LDN;
      end
      LDN: begin
        busy       = 1'b1;
        loadN      = 1'b1;
        state_next = LDP;
      end
      LDP: begin
        busy       = 1'b1;
        loadP      = 1'b1;
`ifdef DIV_ZERO_CHECK_EN
        if (data_zero) begin
          state_next = STOPZ;
          err_set    = 1'b1;
        end else begin
          state_next = ITER;
        end
`else
        state_next = ITER;
`endif
      end
      ITER: begin
        busy = 1'b1;
        // Compare flag still set with the counter exhausted means overflow.
        if (PgtN && !at_max) begin
          incQ = 1'b1;
        end else begin
          stop       = 1'b1;
          err_set    = PgtN;
          state_next = DONE;
        end
      end
      STOPZ: begin
        busy       = 1'b1;
        stop       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_div_controller.sv
// tb/tb_div_controller.sv - randomized self-checking bench for div_controller with a behavioural datapath
module tb_div_controller;
  import div_pkg::*;

  localparam int MAXI = DEFAULT_MAX_ITER;

  logic clk = 1'b0;
  logic rst, start, data_zero, PgtN;
  logic clear, loadN, loadP, loadS, incQ, stop, busy, done, err;
  logic [7:0] data_in;
  logic [7:0] n_reg = 8'd0, p_reg = 8'd0, q_reg = 8'd0, res = 8'd0, rem = 8'd0;
  int cur_n = 0, cur_p = 0;
  int checks = 0, errors = 0;

  div_controller dut (
    .clk(clk), .rst(rst), .start(start), .data_zero(data_zero), .PgtN(PgtN),
    .clear(clear), .loadN(loadN), .loadP(loadP), .loadS(loadS), .incQ(incQ),
    .stop(stop), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Host and datapath stand-in: dividend on loadN, divisor otherwise.
  always_comb begin
    data_in   = loadN ? 8'(cur_n) : 8'(cur_p);
    data_zero = (data_in == 8'd0);
    PgtN      = (n_reg >= p_reg);
  end

  always @(posedge clk) begin
    if (clear) begin
      n_reg <= 8'd0;
      p_reg <= 8'd0;
      q_reg <= 8'd0;
    end
    if (loadN) n_reg <= data_in;
    if (loadP) p_reg <= data_in;
    if (incQ) begin
      n_reg <= n_reg - p_reg;
      q_reg <= q_reg + 8'd1;
    end
    if (stop) begin
      res <= q_reg;
      rem <= n_reg;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int outs();
    return int'({clear, loadN, loadP, loadS, incQ, stop, busy, done, err});
  endfunction

  // Quotient and error flag from plain arithmetic, capped by the iteration budget.
  task automatic model(input int n, input int p, output int q, output int e);
`ifdef DIV_ZERO_CHECK_EN
    if (p == 0) begin
      q = 0;
      e = 1;
      return;
    end
`endif
    if (p == 0) begin
      q = MAXI;
      e = 1;
    end else begin
      q = n / p;
      e = 0;
      if (q > MAXI) begin
        q = MAXI;
        e = 1;
      end
    end
  endtask

  task automatic run_div(input int n, input int p, input int pa, input int pb, input bit retrig);
    int q, e, ext, c;
    int clr_n, clr_c, ldn_n, ldn_c, ldp_n, ldp_c, inc_n, inc_bad, stop_n, stop_c;
    int done_c, err_d, busy_bad, ls_bad;
    model(n, p, q, e);
    cur_n = n;
    cur_p = p;
    clr_n = 0; clr_c = 0; ldn_n = 0; ldn_c = 0; ldp_n = 0; ldp_c = 0;
    inc_n = 0; inc_bad = 0; stop_n = 0; stop_c = 0; done_c = 0; err_d = -1;
    busy_bad = 0; ls_bad = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (clear) begin clr_n++; clr_c = c; end
      if (loadN) begin ldn_n++; ldn_c = c; end
      if (loadP) begin ldp_n++; ldp_c = c; end
      if (incQ) begin
        inc_n++;
        if (c < 4 || c > 3 + q) inc_bad++;
      end
      if (stop) begin stop_n++; stop_c = c; end
      if (!busy) busy_bad++;
      if (loadS) ls_bad++;
      if (done) begin
        done_c = c;
        err_d  = int'(err);
        break;
      end
      start = (c == pa || c == pb);
    end
    check("clear_cyc", (clr_n == 1) ? clr_c : -1, 1);
    check("loadN_cyc", (ldn_n == 1) ? ldn_c : -1, 2);
    check("loadP_cyc", (ldp_n == 1) ? ldp_c : -1, 3);
    check("incQ_count", inc_n, q);
    check("incQ_window", inc_bad, 0);
    check("stop_cyc", (stop_n == 1) ? stop_c : -1, 4 + q);
    check("done_cyc", done_c, 5 + q);
    check("err_at_done", err_d, e);
    check("busy_low", busy_bad, 0);
    check("loadS_high", ls_bad, 0);
    check("res", int'(res), q);
    check("rem", int'(rem), n - q * p);
    start = retrig;
    @(negedge clk);
    check("err_hold", int'(err), e);
    check("idle_busy", int'(busy), 0);
    if (retrig) begin
      check("retrig_in_done", int'(clear), 0);
      @(negedge clk);
      check("retrig_clear", int'(clear), 1);
      check("err_cleared", int'(err), 0);
      start = 1'b0;
      ext = 0;
      for (int k = 0; k < 300 && !done; k++) @(negedge clk);
      check("retrig_done", int'(done), 1);
      @(negedge clk);
    end else begin
      ext = 0;
      repeat (6) begin
        @(negedge clk);
        if (clear || done) ext++;
      end
      check("extra_activity", ext, 0);
    end
  endtask

  initial begin
    int k, rn, rp;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 0);
    rst = 1'b0;

    run_div(20, 6, 0, 0, 1'b0);
    run_div(5, 7, 0, 0, 1'b0);
    run_div(255, 1, 0, 0, 1'b0);
    run_div(9, 0, 0, 0, 1'b0);

    // Reset must also drop a held error flag.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_clears_err", outs(), 0);

    run_div(20, 6, 2, 6, 1'b0);
    run_div(100, 7, 0, 0, 1'b1);

    // Reset mid-division after two subtract pulses.
    cur_n = 200;
    cur_p = 3;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    k = 0;
    for (int c = 1; c <= 20 && k < 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (incQ) k++;
    end
    check("pulses_before_rst", k, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_iter", outs(), 0);
    repeat (3) @(negedge clk);
    check("rst_stays_idle", outs(), 0);
    run_div(200, 3, 0, 0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      rn = int'($urandom_range(0, 255));
      rp = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      run_div(rn, rp, 0, 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
